// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle for pipe_stage_reg: upstream entry in, held entry out.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 6
);
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;

  modport slave (
    input  valid_i, ctrl_i, data_i, out_ready_i,
    output ready_o, out_valid_o, ctrl_o, data_o
  );

  modport master (
    output valid_i, ctrl_i, data_i, out_ready_i,
    input  ready_o, out_valid_o, ctrl_o, data_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register with stall, flush and bubble-zeroed control bits.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  pipe_stage_reg_if.slave   bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              ready, out_valid, accept, rel;

  assign ready     = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.valid_i & ready & ~stall_i & ~flush_i;
  assign rel       = out_valid & bus.out_ready_i & ~stall_i & ~flush_i;

  assign bus.ready_o     = ready;
  assign bus.out_valid_o = out_valid;
  assign bus.ctrl_o      = main_ctrl_q;
  assign bus.data_o      = main_data_q;

  // Control fields are zeroed whenever their entry becomes invalid so ctrl_o
  // is already a bubble straight from the register.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_ctrl_d = bus.ctrl_i;
            main_data_d = bus.data_i;
          end
        end
        ONE: begin
          if (accept && rel) begin
            main_ctrl_d = bus.ctrl_i;
            main_data_d = bus.data_i;
          end else if (accept) begin
            state_d     = FULL;
            skid_ctrl_d = bus.ctrl_i;
            skid_data_d = bus.data_i;
          end else if (rel) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
        FULL: begin
          if (rel) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: FIFO-of-depth-2 reference model, directed scenarios then random traffic.
module tb_pipe_stage_reg;
  localparam int unsigned DW = 128;
  localparam int unsigned CW = 6;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  logic flush;
  int   n_chk  = 0;
  int   n_pass = 0;
  ent_t q[$];

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .stall_i (stall),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Monitor: the queue holds exactly the entries the stage should be holding, oldest first.
  always @(negedge clk) begin
    chk("out_valid", DW'(bus.out_valid_o), DW'(q.size() > 0));
    chk("ready", DW'(bus.ready_o), DW'(q.size() < 2));
    if (q.size() > 0) begin
      chk("data_o", bus.data_o, q[0].d);
      chk("ctrl_o", DW'(bus.ctrl_o), DW'(q[0].c));
      if (bus.out_ready_i && !stall && !flush && rst_n) void'(q.pop_front());
    end else begin
      chk("bubble_ctrl", DW'(bus.ctrl_o), '0);
    end
  end

  // Drives one cycle of inputs just after a rising edge, then commits the
  // model update once the following edge has happened.
  task automatic cycle(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit ordy, input bit st, input bit fl);
    bit acc;
    bus.valid_i     = v;
    bus.ctrl_i      = c;
    bus.data_i      = d;
    bus.out_ready_i = ordy;
    stall           = st;
    flush           = fl;
    acc = v && bus.ready_o && !st && !fl;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else if (acc) q.push_back('{c: c, d: d});
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic fill_full();
    cycle(1'b1, 6'h11, 128'hF1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 6'h22, 128'hF2, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    bus.valid_i = 1'b0;
    bus.ctrl_i = '0;
    bus.data_i = '0;
    bus.out_ready_i = 1'b0;
    #1;
    chk("rst_valid", DW'(bus.out_valid_o), '0);
    chk("rst_ctrl", DW'(bus.ctrl_o), '0);
    chk("rst_data", bus.data_o, '0);
    chk("rst_ready", DW'(bus.ready_o), DW'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // streaming 1,2,3
    for (int unsigned i = 1; i <= 3; i++) cycle(1'b1, 6'(i), DW'(i), 1'b1, 1'b0, 1'b0);
    repeat (2) idle(1'b1);

    // backpressure 0xA,0xB
    cycle(1'b1, 6'h0A, 128'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 6'h0B, 128'hB, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_low", DW'(bus.ready_o), '0);
    cycle(1'b1, 6'h0C, 128'hC, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b1);

    // stall in FULL with downstream ready
    fill_full();
    repeat (3) cycle(1'b1, 6'h33, 128'hF3, 1'b1, 1'b1, 1'b0);
    chk("stall_data", bus.data_o, 128'hF1);
    chk("stall_ready", DW'(bus.ready_o), '0);
    repeat (3) idle(1'b1);

    // flush beats stall and valid
    fill_full();
    cycle(1'b1, 6'h3F, 128'hEE, 1'b1, 1'b1, 1'b1);
    chk("flush_valid", DW'(bus.out_valid_o), '0);
    chk("flush_ctrl", DW'(bus.ctrl_o), '0);
    chk("flush_ready", DW'(bus.ready_o), DW'(1));
    idle(1'b1);

    // bubble after full-ones ctrl
    cycle(1'b1, 6'h3F, 128'h5, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("bubble_ctrl_dir", DW'(bus.ctrl_o), '0);
    chk("bubble_valid_dir", DW'(bus.out_valid_o), '0);

    // async reset between edges while FULL
    fill_full();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", DW'(bus.out_valid_o), '0);
    chk("arst_ctrl", DW'(bus.ctrl_o), '0);
    chk("arst_data", bus.data_o, '0);
    chk("arst_ready", DW'(bus.ready_o), DW'(1));
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 6'h01, 128'h77, 1'b1, 1'b0, 1'b0);
    chk("post_rst_accept", bus.data_o, 128'h77);

    // random traffic
    for (int unsigned i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)),
            {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 31) == 0);
    end

    // bounded drain
    for (int unsigned i = 0; i < 10 && q.size() > 0; i++) idle(1'b1);
    chk("drain_empty", DW'(q.size()), '0);
    chk("drain_valid", DW'(bus.out_valid_o), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
